ap3216_seq: RTL and testbench

- Transaction sequencer for the AP3216 ambient-light sensor.
- Drives a byte-level I2C master through a command/response handshake:
  - Boot-time soft reset of the sensor.
  - ALS-only mode configuration.
  - Periodic two-byte ALS reads (low then high).
- Publishes the assembled 16-bit reading plus a 12-bit saturated copy for the backlight brightness path.
- Sits between the I2C master and the brightness smoothing logic. Owns all sensor register traffic.

---
 rtl/ap3216_pkg.sv | 25 ++
 rtl/ms_timer.sv | 45 ++++
 rtl/ap3216_seq.sv | 205 ++++++++++++++++++++
 tb/tb_ap3216_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ap3216_pkg.sv
// Shared register map, configuration values and sequencer state encoding for the
// AP3216 ambient-light sensor sequencer.
package ap3216_pkg;

  localparam logic [7:0] RegSysCfg  = 8'h00;
  localparam logic [7:0] RegAlsLo   = 8'h0C;
  localparam logic [7:0] RegAlsHi   = 8'h0D;
  localparam logic [7:0] CfgSwReset = 8'h04;
  localparam logic [7:0] CfgAlsOnly = 8'h01;

  typedef enum logic [3:0] {
    StBootWait,
    StCfgRst,
    StRstWait,
    StCfgMode,
    StConvWait,
    StRdLo,
    StRdHi,
    StPublish,
    StRspWait,
    StBackoff,
    StErrWait
  } state_t;

endpackage

// File: rtl/ms_timer.sv
// Millisecond timer: a prescaler producing a 1 ms tick plus a tick counter that flags
// the N-th tick after the most recent start.
module ms_timer #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        start_i,
  input  logic [15:0] ms_i,
  output logic        done_o
);

  localparam int unsigned PreDiv = (CLK_FREQ / 1000 > 1) ? CLK_FREQ / 1000 : 2;
  localparam int unsigned PreW   = $clog2(PreDiv);

  logic [PreW-1:0] pre_q, pre_d;
  logic [15:0]     ms_q, ms_d;
  logic            tick;

  assign tick   = (pre_q == PreW'(PreDiv - 1));
  assign done_o = tick && (ms_q == ms_i - 16'd1);

  always_comb begin
    pre_d = pre_q + PreW'(1);
    ms_d  = ms_q;
    if (start_i) begin
      pre_d = '0;
      ms_d  = '0;
    end else if (tick) begin
      pre_d = '0;
      ms_d  = ms_q + 16'd1;
    end
  end

  always_ff @(posedge I_clk or negedge I_reset) begin
    if (!I_reset) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else begin
      pre_q <= pre_d;
      ms_q  <= ms_d;
    end
  end

endmodule

// File: rtl/ap3216_seq.sv
// AP3216 transaction sequencer: soft reset, ALS-only configuration, then periodic
// two-byte ALS reads published as a raw 16-bit value and a 12-bit saturated copy.
module ap3216_seq
  import ap3216_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter logic [6:0]  DEV_ADDR  = 7'h1E,
  parameter int unsigned BOOT_MS   = 10,
  parameter int unsigned RST_MS    = 10,
  parameter int unsigned POLL_MS   = 100,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        I_clk,
  input  logic        I_reset,
  output logic        O_cmd_valid,
  input  logic        I_cmd_ready,
  output logic        O_cmd_rw,
  output logic [6:0]  O_cmd_dev,
  output logic [7:0]  O_cmd_reg,
  output logic [7:0]  O_cmd_wdata,
  input  logic        I_rsp_valid,
  input  logic        I_rsp_nack,
  input  logic [7:0]  I_rsp_rdata,
  output logic [15:0] O_als_raw,
  output logic [11:0] O_als_sat12,
  output logic        O_als_valid,
  output logic        O_cfg_done,
  output logic        O_err
);

  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t             state_q, state_d;
  state_t             ret_q, ret_d;
  logic [RetryW-1:0]  retry_q, retry_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               cmd_rw_q, cmd_rw_d;
  logic [7:0]         cmd_reg_q, cmd_reg_d;
  logic [7:0]         cmd_wdata_q, cmd_wdata_d;
  logic [7:0]         lo_q, lo_d;
  logic [7:0]         hi_q, hi_d;
  logic [15:0]        als_raw_q, als_raw_d;
  logic [11:0]        als_sat_q, als_sat_d;
  logic               als_valid_q, als_valid_d;
  logic               cfg_done_q, cfg_done_d;
  logic               err_q, err_d;
  logic [15:0]        tmr_ms;
  logic               tmr_start;
  logic               tmr_done;

  ms_timer #(
    .CLK_FREQ (CLK_FREQ)
  ) u_ms_timer (
    .I_clk   (I_clk),
    .I_reset (I_reset),
    .start_i (tmr_start),
    .ms_i    (tmr_ms),
    .done_o  (tmr_done)
  );

  // Any state change restarts the timer, so every wait state begins from zero.
  assign tmr_start = (state_d != state_q);

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    retry_d     = retry_q;
    cmd_valid_d = cmd_valid_q;
    cmd_rw_d    = cmd_rw_q;
    cmd_reg_d   = cmd_reg_q;
    cmd_wdata_d = cmd_wdata_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    als_raw_d   = als_raw_q;
    als_sat_d   = als_sat_q;
    als_valid_d = 1'b0;
    cfg_done_d  = cfg_done_q;
    err_d       = err_q;
    tmr_ms      = 16'd1;

    unique case (state_q)
      StBootWait: begin
        tmr_ms = 16'(BOOT_MS);
        if (tmr_done) state_d = StCfgRst;
      end
      StRstWait: begin
        tmr_ms = 16'(RST_MS);
        if (tmr_done) state_d = StCfgMode;
      end
      StErrWait: begin
        tmr_ms = 16'(RST_MS);
        if (tmr_done) state_d = StCfgRst;
      end
      StConvWait: begin
        tmr_ms = 16'(POLL_MS);
        if (tmr_done) state_d = StRdLo;
      end
      StBackoff: begin
        tmr_ms = 16'd1;
        if (tmr_done) state_d = ret_q;
      end
      StCfgRst, StCfgMode, StRdLo, StRdHi: begin
        if (!cmd_valid_q) begin
          cmd_valid_d = 1'b1;
          cmd_rw_d    = (state_q == StRdLo) || (state_q == StRdHi);
          cmd_reg_d   = (state_q == StRdLo) ? RegAlsLo :
                        (state_q == StRdHi) ? RegAlsHi : RegSysCfg;
          cmd_wdata_d = (state_q == StCfgRst)  ? CfgSwReset :
                        (state_q == StCfgMode) ? CfgAlsOnly : 8'h00;
        end else if (I_cmd_ready) begin
          cmd_valid_d = 1'b0;
          ret_d       = state_q;
          state_d     = StRspWait;
        end
      end
      StRspWait: begin
        if (I_rsp_valid) begin
          if (I_rsp_nack) begin
            if (retry_q < RetryW'(MAX_RETRY)) begin
              retry_d = retry_q + RetryW'(1);
              state_d = StBackoff;
            end else begin
              retry_d    = '0;
              err_d      = 1'b1;
              cfg_done_d = 1'b0;
              state_d    = StErrWait;
            end
          end else begin
            retry_d = '0;
            unique case (ret_q)
              StCfgRst:  state_d = StRstWait;
              StCfgMode: begin
                cfg_done_d = 1'b1;
                err_d      = 1'b0;
                state_d    = StConvWait;
              end
              StRdLo: begin
                lo_d    = I_rsp_rdata;
                state_d = StRdHi;
              end
              StRdHi: begin
                hi_d    = I_rsp_rdata;
                state_d = StPublish;
              end
              default: state_d = StCfgRst;
            endcase
          end
        end
      end
      StPublish: begin
        als_raw_d   = {hi_q, lo_q};
        als_sat_d   = (hi_q[7:4] != 4'h0) ? 12'hFFF : {hi_q[3:0], lo_q};
        als_valid_d = 1'b1;
        state_d     = StConvWait;
      end
      default: state_d = StBootWait;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset) begin
    if (!I_reset) begin
      state_q     <= StBootWait;
      ret_q       <= StBootWait;
      retry_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_rw_q    <= 1'b0;
      cmd_reg_q   <= 8'h00;
      cmd_wdata_q <= 8'h00;
      lo_q        <= 8'h00;
      hi_q        <= 8'h00;
      als_raw_q   <= 16'h0000;
      als_sat_q   <= 12'h000;
      als_valid_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      retry_q     <= retry_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_rw_q    <= cmd_rw_d;
      cmd_reg_q   <= cmd_reg_d;
      cmd_wdata_q <= cmd_wdata_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      als_raw_q   <= als_raw_d;
      als_sat_q   <= als_sat_d;
      als_valid_q <= als_valid_d;
      cfg_done_q  <= cfg_done_d;
      err_q       <= err_d;
    end
  end

  assign O_cmd_valid = cmd_valid_q;
  assign O_cmd_rw    = cmd_rw_q;
  assign O_cmd_dev   = DEV_ADDR;
  assign O_cmd_reg   = cmd_reg_q;
  assign O_cmd_wdata = cmd_wdata_q;
  assign O_als_raw   = als_raw_q;
  assign O_als_sat12 = als_sat_q;
  assign O_als_valid = als_valid_q;
  assign O_cfg_done  = cfg_done_q;
  assign O_err       = err_q;

endmodule

// File: tb/tb_ap3216_seq.sv
// Directed bench for ap3216_seq with a small I2C master model (ready 2 cycles after
// a request, response 5 cycles after accept) and a command log for timing checks.
module tb_ap3216_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [6:0]  cmd_dev;
  logic [7:0]  cmd_reg, cmd_wdata;
  logic        rsp_valid, rsp_nack;
  logic [7:0]  rsp_rdata;
  logic [15:0] als_raw;
  logic [11:0] als_sat;
  logic        als_valid, cfg_done, err;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Master model controls
  logic [7:0] lo_val = 8'h34;
  logic [7:0] hi_val = 8'h02;
  int nack_hi_left = 0;
  int nack_mode_left = 0;

  // Command log, filled at accept time
  int         log_n = 0;
  int         log_cyc [0:255];
  logic [7:0] log_reg [0:255];
  logic [7:0] log_wd  [0:255];
  logic       log_rw  [0:255];

  // ALS pulse monitor
  int          pulse_n = 0;
  int          wide_n = 0;
  logic        prev_v = 1'b0;
  logic [15:0] cap_raw;
  logic [11:0] cap_sat;

  ap3216_seq #(
    .CLK_FREQ (10_000)
  ) dut (
    .I_clk       (clk),
    .I_reset     (rst_n),
    .O_cmd_valid (cmd_valid),
    .I_cmd_ready (cmd_ready),
    .O_cmd_rw    (cmd_rw),
    .O_cmd_dev   (cmd_dev),
    .O_cmd_reg   (cmd_reg),
    .O_cmd_wdata (cmd_wdata),
    .I_rsp_valid (rsp_valid),
    .I_rsp_nack  (rsp_nack),
    .I_rsp_rdata (rsp_rdata),
    .O_als_raw   (als_raw),
    .O_als_sat12 (als_sat),
    .O_als_valid (als_valid),
    .O_cfg_done  (cfg_done),
    .O_err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (als_valid) begin
      pulse_n++;
      cap_raw = als_raw;
      cap_sat = als_sat;
      if (prev_v) wide_n++;
    end
    prev_v = als_valid;
  end

  initial begin : master_model
    logic       m_rw;
    logic [7:0] m_reg, m_wd;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
    rsp_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && cmd_valid) begin
        m_rw  = cmd_rw;
        m_reg = cmd_reg;
        m_wd  = cmd_wdata;
        repeat (2) @(negedge clk);
        cmd_ready = 1'b1;
        if (log_n < 256) begin
          log_cyc[log_n] = cyc;
          log_reg[log_n] = m_reg;
          log_wd[log_n]  = m_wd;
          log_rw[log_n]  = m_rw;
          log_n++;
        end
        @(negedge clk);
        cmd_ready = 1'b0;
        repeat (4) @(negedge clk);
        rsp_nack  = 1'b0;
        rsp_rdata = 8'h00;
        if (m_rw) begin
          if (m_reg == 8'h0C) begin
            rsp_rdata = lo_val;
          end else begin
            rsp_rdata = hi_val;
            if (nack_hi_left > 0) begin
              rsp_nack = 1'b1;
              nack_hi_left--;
            end
          end
        end else if (m_wd == 8'h01 && nack_mode_left > 0) begin
          rsp_nack = 1'b1;
          nack_mode_left--;
        end
        rsp_valid = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
      end
    end
  end

  int rel_cyc;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
    n_cmp++; if ({cmd_rw, cmd_reg, cmd_wdata} !== 17'h0) begin n_fail++;
      $display("FAIL reset_cmd_fields: got %h want 0", {cmd_rw, cmd_reg, cmd_wdata}); end
    n_cmp++; if (cmd_dev !== 7'h1E) begin n_fail++;
      $display("FAIL reset_cmd_dev: got %h want 1e", cmd_dev); end
    n_cmp++; if ({als_raw, als_sat, als_valid} !== 29'h0) begin n_fail++;
      $display("FAIL reset_als: got %h/%h/%b want 0", als_raw, als_sat, als_valid); end
    n_cmp++; if ({cfg_done, err} !== 2'b00) begin n_fail++;
      $display("FAIL reset_flags: got %b%b want 00", cfg_done, err); end
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic test_boot_config();
    int t;
    t = 0;
    while (log_n < 1 && t < 300) begin @(negedge clk); t++; end
    n_cmp++; if (log_n < 1) begin n_fail++;
      $display("FAIL boot_first_cmd: got none want soft reset write"); end
    n_cmp++; if ({log_rw[0], log_reg[0], log_wd[0]} !== {1'b0, 8'h00, 8'h04}) begin n_fail++;
      $display("FAIL boot_rst_cmd: got %h want 00004", {log_rw[0], log_reg[0], log_wd[0]}); end
    n_cmp++; if (log_cyc[0] - rel_cyc < 98 || log_cyc[0] - rel_cyc > 108) begin n_fail++;
      $display("FAIL boot_latency: got %0d want 98..108", log_cyc[0] - rel_cyc); end
    t = 0;
    while (log_n < 2 && t < 300) begin @(negedge clk); t++; end
    n_cmp++; if ({log_rw[1], log_reg[1], log_wd[1]} !== {1'b0, 8'h00, 8'h01}) begin n_fail++;
      $display("FAIL boot_mode_cmd: got %h want 00001", {log_rw[1], log_reg[1], log_wd[1]}); end
    n_cmp++; if (log_cyc[1] - log_cyc[0] < 105 || log_cyc[1] - log_cyc[0] > 115) begin n_fail++;
      $display("FAIL boot_mode_gap: got %0d want 105..115", log_cyc[1] - log_cyc[0]); end
    t = 0;
    while (cfg_done !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    n_cmp++; if ({cfg_done, err} !== 2'b10) begin n_fail++;
      $display("FAIL boot_cfg_done: got %b%b want 10", cfg_done, err); end
  endtask

  task automatic test_read_assembly();
    int t, lo_idx, p0;
    p0 = pulse_n;
    t = 0;
    while (pulse_n == p0 && t < 1500) begin @(negedge clk); t++; end
    n_cmp++; if (cap_raw !== 16'h0234 || pulse_n == p0) begin n_fail++;
      $display("FAIL read_raw: got %h want 0234", cap_raw); end
    n_cmp++; if (cap_sat !== 12'h234) begin n_fail++;
      $display("FAIL read_sat: got %h want 234", cap_sat); end
    n_cmp++; if (wide_n !== 0) begin n_fail++;
      $display("FAIL read_pulse_width: got %0d wide want 0", wide_n); end
    lo_idx = log_n - 2;
    n_cmp++; if ({log_rw[lo_idx], log_reg[lo_idx], log_rw[lo_idx+1], log_reg[lo_idx+1]}
                 !== {1'b1, 8'h0C, 1'b1, 8'h0D}) begin n_fail++;
      $display("FAIL read_regs: got %h/%h want 0c/0d", log_reg[lo_idx], log_reg[lo_idx+1]); end
    t = 0;
    while (log_n == lo_idx + 2 && t < 1200) begin @(negedge clk); t++; end
    n_cmp++; if (log_reg[lo_idx+2] !== 8'h0C ||
                 log_cyc[lo_idx+2] - log_cyc[lo_idx] < 1010 ||
                 log_cyc[lo_idx+2] - log_cyc[lo_idx] > 1030) begin n_fail++;
      $display("FAIL read_poll_gap: got reg %h gap %0d want 0c 1010..1030",
               log_reg[lo_idx+2], log_cyc[lo_idx+2] - log_cyc[lo_idx]); end
  endtask

  task automatic test_saturation();
    int t, p0;
    lo_val = 8'hFF;
    hi_val = 8'h12;
    p0 = pulse_n;
    t = 0;
    while (pulse_n == p0 && t < 100) begin @(negedge clk); t++; end
    n_cmp++; if (cap_raw !== 16'h12FF || pulse_n == p0) begin n_fail++;
      $display("FAIL sat_raw: got %h want 12ff", cap_raw); end
    n_cmp++; if (cap_sat !== 12'hFFF) begin n_fail++;
      $display("FAIL sat_sat12: got %h want fff", cap_sat); end
  endtask

  task automatic test_nack_retry();
    int t, p0, s, n_lo, n_hi, last_hi, min_gap;
    lo_val = 8'h56;
    hi_val = 8'h01;
    nack_hi_left = 2;
    p0 = pulse_n;
    s = log_n;
    t = 0;
    while (pulse_n == p0 && t < 1300) begin @(negedge clk); t++; end
    n_cmp++; if (cap_raw !== 16'h0156 || pulse_n == p0) begin n_fail++;
      $display("FAIL nack_raw: got %h want 0156", cap_raw); end
    n_cmp++; if ({err, cfg_done} !== 2'b01) begin n_fail++;
      $display("FAIL nack_flags: got err %b cfg %b want 0 1", err, cfg_done); end
    n_lo = 0; n_hi = 0; last_hi = -1; min_gap = 1000000;
    for (int i = s; i < log_n; i++) begin
      if (log_reg[i] == 8'h0C) n_lo++;
      if (log_reg[i] == 8'h0D) begin
        n_hi++;
        if (last_hi >= 0 && log_cyc[i] - last_hi < min_gap) min_gap = log_cyc[i] - last_hi;
        last_hi = log_cyc[i];
      end
    end
    n_cmp++; if (n_lo !== 1 || n_hi !== 3) begin n_fail++;
      $display("FAIL nack_cmd_count: got lo %0d hi %0d want 1 3", n_lo, n_hi); end
    n_cmp++; if (min_gap < 10) begin n_fail++;
      $display("FAIL nack_backoff: got gap %0d want >=10", min_gap); end
  endtask

  task automatic test_retry_exhaust();
    int t, s, n_mode, k;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    nack_mode_left = 4;
    s = log_n;
    rst_n = 1'b1;
    t = 0;
    while (err !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    n_cmp++; if ({err, cfg_done} !== 2'b10) begin n_fail++;
      $display("FAIL exhaust_flags: got err %b cfg %b want 1 0", err, cfg_done); end
    n_mode = 0;
    for (int i = s; i < log_n; i++) if (log_wd[i] == 8'h01) n_mode++;
    n_cmp++; if (n_mode !== 4 || log_n - s !== 5) begin n_fail++;
      $display("FAIL exhaust_cmd_count: got mode %0d total %0d want 4 5", n_mode, log_n - s); end
    k = log_n;
    t = 0;
    while (log_n == k && t < 300) begin @(negedge clk); t++; end
    n_cmp++; if (log_reg[k] !== 8'h00 || log_wd[k] !== 8'h04 ||
                 log_cyc[k] - log_cyc[k-1] < 105 || log_cyc[k] - log_cyc[k-1] > 115) begin
      n_fail++;
      $display("FAIL exhaust_reinit: got %h/%h gap %0d want 00/04 105..115",
               log_reg[k], log_wd[k], log_cyc[k] - log_cyc[k-1]); end
    t = 0;
    while (cfg_done !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    n_cmp++; if ({err, cfg_done} !== 2'b01) begin n_fail++;
      $display("FAIL exhaust_recover: got err %b cfg %b want 0 1", err, cfg_done); end
  endtask

  task automatic test_reset_midop();
    int t, p0, s;
    p0 = pulse_n;
    t = 0;
    while (pulse_n == p0 && t < 1300) begin @(negedge clk); t++; end
    t = 0;
    while (!(cmd_valid === 1'b1 && cmd_ready === 1'b0) && t < 1200) begin
      @(negedge clk); t++;
    end
    n_cmp++; if (cmd_valid !== 1'b1 || als_raw !== 16'h0156) begin n_fail++;
      $display("FAIL midop_setup: got valid %b raw %h want 1 0156", cmd_valid, als_raw); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++;
      $display("FAIL midop_valid_drop: got %b want 0", cmd_valid); end
    n_cmp++; if ({als_raw, als_sat, cfg_done, err} !== 30'h0) begin n_fail++;
      $display("FAIL midop_outputs: got %h/%h/%b%b want 0", als_raw, als_sat, cfg_done, err); end
    repeat (12) @(negedge clk);
    s = log_n;
    rst_n = 1'b1;
    rel_cyc = cyc;
    t = 0;
    while (log_n == s && t < 300) begin @(negedge clk); t++; end
    n_cmp++; if (log_n == s || log_reg[s] !== 8'h00 || log_wd[s] !== 8'h04 ||
                 log_cyc[s] - rel_cyc < 98 || log_cyc[s] - rel_cyc > 108) begin n_fail++;
      $display("FAIL midop_reboot: got %h/%h lat %0d want 00/04 98..108",
               log_reg[s], log_wd[s], log_cyc[s] - rel_cyc); end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_boot_config();
    test_read_assembly();
    test_saturation();
    test_nack_retry();
    test_retry_exhaust();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
